// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: MEM/WB writeback, long-latency result handshake,
// regfile write port and the status seen by the hazard unit.
interface wb_port_arbiter_if #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
);
    logic                  pipe_we;
    logic [REG_ADDR_W-1:0] pipe_rd;
    logic [XLEN-1:0]       pipe_wdata;

    logic                  lu_valid;
    logic [REG_ADDR_W-1:0] lu_rd;
    logic [XLEN-1:0]       lu_data;
    logic                  lu_ready;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [XLEN-1:0]       rf_wdata;

    logic                  stall_req;
    logic                  buf_valid;
    logic [REG_ADDR_W-1:0] buf_rd;

    // Pipeline / long-latency unit / regfile side as seen from outside the arbiter
    modport master (
        output pipe_we, pipe_rd, pipe_wdata,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  stall_req, buf_valid, buf_rd
    );

    modport slave (
        input  pipe_we, pipe_rd, pipe_wdata,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready,
        output rf_we, rf_waddr, rf_wdata,
        output stall_req, buf_valid, buf_rd
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single regfile write port between MEM/WB writeback (always first) and an
// out-of-order long-latency unit, via a 1-entry holding buffer and a bounded-wait stall.
module wb_port_arbiter #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    wb_port_arbiter_if.slave  bus
);
    localparam int                CNT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0]  WAIT_MAX  = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HELD  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t                state_reg,     state_next;
    logic [CNT_W-1:0]      wait_cnt_reg,  wait_cnt_next;
    logic                  stall_req_reg;
    logic                  buf_valid_reg, buf_valid_next;
    logic [REG_ADDR_W-1:0] buf_rd_reg,    buf_rd_next;
    logic [XLEN-1:0]       buf_data_reg,  buf_data_next;

    logic pipe_wr;
    logic grant;
    logic kill;
    logic lu_ready;
    logic accept;
    logic load;
    logic [CNT_W-1:0] wait_cnt_inc;

    // Port arbitration: a real pipeline write (rd != x0) always wins the port
    always_comb begin
        pipe_wr  = bus.pipe_we && (bus.pipe_rd != '0);
        grant    = buf_valid_reg && !pipe_wr;
        kill     = pipe_wr && buf_valid_reg && (bus.pipe_rd == buf_rd_reg);
        lu_ready = !buf_valid_reg || grant;
        accept   = bus.lu_valid && lu_ready;
        load     = accept && (bus.lu_rd != '0);
    end

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        if (pipe_wr) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.pipe_rd;
            bus.rf_wdata = bus.pipe_wdata;
        end else if (grant) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = buf_rd_reg;
            bus.rf_wdata = buf_data_reg;
        end
    end

    assign bus.lu_ready  = lu_ready;
    assign bus.stall_req = stall_req_reg;
    assign bus.buf_valid = buf_valid_reg;
    assign bus.buf_rd    = buf_rd_reg;

    // A new result takes priority over draining: grant+accept reloads with no bubble
    always_comb begin
        buf_valid_next = buf_valid_reg;
        buf_rd_next    = buf_rd_reg;
        buf_data_next  = buf_data_reg;
        if (load) begin
            buf_valid_next = 1'b1;
            buf_rd_next    = bus.lu_rd;
            buf_data_next  = bus.lu_data;
        end else if (grant || kill) begin
            buf_valid_next = 1'b0;
        end
    end

    assign wait_cnt_inc = (wait_cnt_reg == WAIT_MAX) ? WAIT_MAX : wait_cnt_reg + CNT_W'(1);

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                wait_cnt_next = '0;
                if (load) begin
                    state_next = ST_HELD;
                end
            end
            ST_HELD: begin
                if (load) begin
                    state_next    = ST_HELD;
                    wait_cnt_next = '0;
                end else if (grant || kill) begin
                    state_next    = ST_IDLE;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_inc;
                    if (wait_cnt_reg == WAIT_LAST) begin
                        state_next = ST_FORCE;
                    end
                end
            end
            ST_FORCE: begin
                // Normally granted here; a pipeline write anyway keeps us waiting in FORCE
                if (load) begin
                    state_next    = ST_HELD;
                    wait_cnt_next = '0;
                end else if (grant || kill) begin
                    state_next    = ST_IDLE;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_inc;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= '0;
            stall_req_reg <= 1'b0;
            buf_valid_reg <= 1'b0;
            buf_rd_reg    <= '0;
            buf_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            stall_req_reg <= (state_next == ST_FORCE);
            buf_valid_reg <= buf_valid_next;
            buf_rd_reg    <= buf_rd_next;
            buf_data_reg  <= buf_data_next;
        end
    end

    // The stall exists to free the port; a pipeline write during it breaks the integration contract
    a_no_pipe_write_in_force: assert property (@(posedge clk) disable iff (!reset)
        !((state_reg == ST_FORCE) && bus.pipe_we));

    a_state_tracks_buffer: assert property (@(posedge clk) disable iff (!reset)
        ((state_reg == ST_IDLE) == !buf_valid_reg));

    a_wait_cnt_bounded: assert property (@(posedge clk) disable iff (!reset)
        (wait_cnt_reg <= WAIT_MAX));
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic
// against a queue-level model of the holding buffer and its bounded wait.
module tb_wb_port_arbiter;
    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int MAX_WAIT   = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    wb_port_arbiter_if #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) bus_if ();

    wb_port_arbiter #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic pwe, input logic [4:0] prd, input logic [63:0] pdat,
                          input logic lv, input logic [4:0] lrd, input logic [63:0] ldat);
        bus_if.pipe_we    = pwe;
        bus_if.pipe_rd    = prd;
        bus_if.pipe_wdata = pdat;
        bus_if.lu_valid   = lv;
        bus_if.lu_rd      = lrd;
        bus_if.lu_data    = ldat;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (bus_if.buf_valid !== 1'b0) begin n_bad++; $display("FAIL reset_buf_valid got=%0b exp=0", bus_if.buf_valid); end
        n_cmp++; if (bus_if.buf_rd !== 5'd0) begin n_bad++; $display("FAIL reset_buf_rd got=%0d exp=0", bus_if.buf_rd); end
        n_cmp++; if (bus_if.stall_req !== 1'b0) begin n_bad++; $display("FAIL reset_stall_req got=%0b exp=0", bus_if.stall_req); end
        n_cmp++; if (bus_if.rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_rf_we got=%0b exp=0", bus_if.rf_we); end
        n_cmp++; if (bus_if.lu_ready !== 1'b1) begin n_bad++; $display("FAIL reset_lu_ready got=%0b exp=1", bus_if.lu_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_pipe_path();
        @(negedge clk);
        set_in(1, 5, 64'hAA, 0, 0, 0);
        #1;
        n_cmp++; if (bus_if.rf_we !== 1'b1) begin n_bad++; $display("FAIL pipe_rf_we got=%0b exp=1", bus_if.rf_we); end
        n_cmp++; if (bus_if.rf_waddr !== 5'd5) begin n_bad++; $display("FAIL pipe_rf_waddr got=%0d exp=5", bus_if.rf_waddr); end
        n_cmp++; if (bus_if.rf_wdata !== 64'hAA) begin n_bad++; $display("FAIL pipe_rf_wdata got=%0h exp=aa", bus_if.rf_wdata); end
        n_cmp++; if (bus_if.lu_ready !== 1'b1) begin n_bad++; $display("FAIL pipe_lu_ready got=%0b exp=1", bus_if.lu_ready); end
        @(negedge clk);
        set_in(1, 0, 64'h77, 0, 0, 0);
        #1;
        n_cmp++; if (bus_if.rf_we !== 1'b0) begin n_bad++; $display("FAIL pipe_x0_rf_we got=%0b exp=0", bus_if.rf_we); end
        $display("test_pipe_path done");
    endtask

    task automatic test_lu_single();
        @(negedge clk);
        set_in(0, 0, 0, 1, 7, 64'h1234);
        #1;
        n_cmp++; if (bus_if.lu_ready !== 1'b1) begin n_bad++; $display("FAIL lu1_ready got=%0b exp=1", bus_if.lu_ready); end
        n_cmp++; if (bus_if.rf_we !== 1'b0) begin n_bad++; $display("FAIL lu1_early_we got=%0b exp=0", bus_if.rf_we); end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (bus_if.buf_valid !== 1'b1) begin n_bad++; $display("FAIL lu1_buf_valid got=%0b exp=1", bus_if.buf_valid); end
        n_cmp++; if (bus_if.rf_we !== 1'b1 || bus_if.rf_waddr !== 5'd7 || bus_if.rf_wdata !== 64'h1234) begin
            n_bad++; $display("FAIL lu1_write got we=%0b addr=%0d data=%0h exp we=1 addr=7 data=1234", bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus_if.buf_valid !== 1'b0) begin n_bad++; $display("FAIL lu1_buf_clear got=%0b exp=0", bus_if.buf_valid); end
        n_cmp++; if (bus_if.rf_we !== 1'b0) begin n_bad++; $display("FAIL lu1_no_rewrite got=%0b exp=0", bus_if.rf_we); end
        $display("test_lu_single done");
    endtask

    task automatic test_force_stall();
        logic [4:0] prds [4];
        prds = '{5'd3, 5'd4, 5'd6, 5'd8};
        @(negedge clk);
        set_in(0, 0, 0, 1, 9, 64'h9999);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_in(1, prds[i], 64'(i + 100), 0, 0, 0);
            #1;
            n_cmp++; if (bus_if.stall_req !== 1'b0) begin n_bad++; $display("FAIL force_early_stall cyc=%0d got=%0b exp=0", i + 1, bus_if.stall_req); end
            n_cmp++; if (bus_if.rf_waddr !== prds[i] || bus_if.lu_ready !== 1'b0) begin
                n_bad++; $display("FAIL force_blocked cyc=%0d got addr=%0d ready=%0b exp addr=%0d ready=0", i + 1, bus_if.rf_waddr, bus_if.lu_ready, prds[i]); end
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (bus_if.stall_req !== 1'b1) begin n_bad++; $display("FAIL force_stall got=%0b exp=1", bus_if.stall_req); end
        n_cmp++; if (bus_if.rf_we !== 1'b1 || bus_if.rf_waddr !== 5'd9 || bus_if.rf_wdata !== 64'h9999) begin
            n_bad++; $display("FAIL force_grant got we=%0b addr=%0d data=%0h exp we=1 addr=9 data=9999", bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus_if.stall_req !== 1'b0 || bus_if.buf_valid !== 1'b0) begin
            n_bad++; $display("FAIL force_release got stall=%0b buf=%0b exp stall=0 buf=0", bus_if.stall_req, bus_if.buf_valid); end
        $display("test_force_stall done");
    endtask

    task automatic test_waw_kill();
        @(negedge clk);
        set_in(0, 0, 0, 1, 10, 64'hBEEF);
        @(negedge clk);
        set_in(1, 10, 64'h55, 0, 0, 0);
        #1;
        n_cmp++; if (bus_if.rf_waddr !== 5'd10 || bus_if.rf_wdata !== 64'h55) begin
            n_bad++; $display("FAIL waw_pipe_write got addr=%0d data=%0h exp addr=10 data=55", bus_if.rf_waddr, bus_if.rf_wdata); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_in(0, 0, 0, 0, 0, 0);
            #1;
            n_cmp++; if (bus_if.buf_valid !== 1'b0 || bus_if.rf_we !== 1'b0) begin
                n_bad++; $display("FAIL waw_discard cyc=%0d got buf=%0b we=%0b exp buf=0 we=0", i, bus_if.buf_valid, bus_if.rf_we); end
        end
        $display("test_waw_kill done");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_in(0, 0, 0, 1, 11, 64'hB11);
        #1;
        n_cmp++; if (bus_if.lu_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready0 got=%0b exp=1", bus_if.lu_ready); end
        @(negedge clk);
        set_in(0, 0, 0, 1, 12, 64'hB12);
        #1;
        n_cmp++; if (bus_if.rf_we !== 1'b1 || bus_if.rf_waddr !== 5'd11 || bus_if.rf_wdata !== 64'hB11 || bus_if.lu_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_first got we=%0b addr=%0d data=%0h ready=%0b exp we=1 addr=11 data=b11 ready=1", bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata, bus_if.lu_ready); end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (bus_if.rf_we !== 1'b1 || bus_if.rf_waddr !== 5'd12 || bus_if.rf_wdata !== 64'hB12 || bus_if.lu_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_second got we=%0b addr=%0d data=%0h ready=%0b exp we=1 addr=12 data=b12 ready=1", bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata, bus_if.lu_ready); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus_if.rf_we !== 1'b0) begin n_bad++; $display("FAIL b2b_done got=%0b exp=0", bus_if.rf_we); end
        $display("test_back_to_back done");
    endtask

    task automatic test_x0_and_async_reset();
        @(negedge clk);
        set_in(0, 0, 0, 1, 0, 64'hDEAD);
        #1;
        n_cmp++; if (bus_if.lu_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ready got=%0b exp=1", bus_if.lu_ready); end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (bus_if.buf_valid !== 1'b0 || bus_if.rf_we !== 1'b0) begin
            n_bad++; $display("FAIL x0_dropped got buf=%0b we=%0b exp buf=0 we=0", bus_if.buf_valid, bus_if.rf_we); end
        set_in(0, 0, 0, 1, 13, 64'hD13);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_in(1, 5'(i + 1), 64'(i), 0, 0, 0);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (bus_if.stall_req !== 1'b1 || bus_if.buf_valid !== 1'b1 || bus_if.buf_rd !== 5'd13) begin
            n_bad++; $display("FAIL arst_pre got stall=%0b buf=%0b rd=%0d exp stall=1 buf=1 rd=13", bus_if.stall_req, bus_if.buf_valid, bus_if.buf_rd); end
        reset = 1'b0;
        #1;
        n_cmp++; if (bus_if.stall_req !== 1'b0 || bus_if.buf_valid !== 1'b0 || bus_if.rf_we !== 1'b0) begin
            n_bad++; $display("FAIL arst_now got stall=%0b buf=%0b we=%0b exp stall=0 buf=0 we=0", bus_if.stall_req, bus_if.buf_valid, bus_if.rf_we); end
        @(negedge clk);
        reset = 1'b1;
        $display("test_x0_and_async_reset done");
    endtask

    // Model: at most one held result; it leaves when the port is free or a same-rd pipeline
    // write supersedes it, and once it has been blocked MAX_WAIT times the stall is raised.
    task automatic test_random(input int n_cycles);
        logic        m_valid = 1'b0;
        logic [4:0]  m_rd    = '0;
        logic [63:0] m_data  = '0;
        int          m_age   = 0;
        logic        m_stall = 1'b0;
        logic pw, e_we, e_ready, pwe, lv;
        logic [4:0] prd, lrd, e_addr;
        logic [63:0] pdat, ldat, e_data;
        int errs_before = n_bad;
        for (int c = 0; c < n_cycles; c++) begin
            @(negedge clk);
            pwe  = !m_stall && ($urandom_range(0, 9) < 6);
            prd  = 5'($urandom_range(0, 7));
            pdat = {$urandom, $urandom};
            lv   = 1'($urandom_range(0, 1));
            lrd  = 5'($urandom_range(0, 7));
            ldat = {$urandom, $urandom};
            set_in(pwe, prd, pdat, lv, lrd, ldat);
            #1;
            pw      = pwe && (prd != 0);
            e_we    = pw || m_valid;
            e_addr  = pw ? prd : m_rd;
            e_data  = pw ? pdat : m_data;
            e_ready = !m_valid || !pw;
            n_cmp++; if (bus_if.rf_we !== e_we) begin n_bad++; $display("FAIL rnd_rf_we cyc=%0d got=%0b exp=%0b", c, bus_if.rf_we, e_we); end
            if (e_we) begin
                n_cmp++; if (bus_if.rf_waddr !== e_addr || bus_if.rf_wdata !== e_data) begin
                    n_bad++; $display("FAIL rnd_rf_write cyc=%0d got addr=%0d data=%0h exp addr=%0d data=%0h", c, bus_if.rf_waddr, bus_if.rf_wdata, e_addr, e_data); end
            end
            n_cmp++; if (bus_if.lu_ready !== e_ready) begin n_bad++; $display("FAIL rnd_lu_ready cyc=%0d got=%0b exp=%0b", c, bus_if.lu_ready, e_ready); end
            n_cmp++; if (bus_if.stall_req !== m_stall) begin n_bad++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", c, bus_if.stall_req, m_stall); end
            n_cmp++; if (bus_if.buf_valid !== m_valid) begin n_bad++; $display("FAIL rnd_buf_valid cyc=%0d got=%0b exp=%0b", c, bus_if.buf_valid, m_valid); end
            if (m_valid) begin
                n_cmp++; if (bus_if.buf_rd !== m_rd) begin n_bad++; $display("FAIL rnd_buf_rd cyc=%0d got=%0d exp=%0d", c, bus_if.buf_rd, m_rd); end
            end
            // Advance the model across the coming edge
            if (lv && e_ready && lrd != 0) begin
                m_valid = 1'b1; m_rd = lrd; m_data = ldat; m_age = 0;
            end else if (m_valid && (!pw || prd == m_rd)) begin
                m_valid = 1'b0; m_age = 0;
            end else if (m_valid) begin
                m_age++;
            end
            m_stall = m_valid && (m_age >= MAX_WAIT);
        end
        $display("test_random done cycles=%0d new_errors=%0d", n_cycles, n_bad - errs_before);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_pipe_path();
        test_lu_single();
        test_force_stall();
        test_waw_kill();
        test_back_to_back();
        test_x0_and_async_reset();
        test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
